// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // Number of feed cycles needed to push a K-deep skewed wavefront
    // through an S x S array.
    function automatic int feed_len(input int k, input int s);
        return k + 2 * s - 2;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cw(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Handshake/control bundle between the sequencer and its surroundings.
// Optional abort input is present only with SYSTOLIC_SEQ_CTRL_ABORT_EN.
interface systolic_seq_ctrl_if
    import systolic_pkg::*;
#(
    parameter int S = 8,
    parameter int K = 8
);
    localparam int TW = cw(K + 2 * S - 1);
    localparam int RW = cw(S);

    logic          start;
    logic          res_ready;
    logic          busy;
    logic          pe_sn;
    logic [TW-1:0] feed_cnt;
    logic [S-1:0]  a_lane_en;
    logic [S-1:0]  b_lane_en;
    logic          res_valid;
    logic [RW-1:0] res_row;
    logic          done;
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
    logic          abort;

    modport master (output start, res_ready, abort,
                    input  busy, pe_sn, feed_cnt, a_lane_en, b_lane_en,
                           res_valid, res_row, done);
    modport slave  (input  start, res_ready, abort,
                    output busy, pe_sn, feed_cnt, a_lane_en, b_lane_en,
                           res_valid, res_row, done);
`else
    modport master (output start, res_ready,
                    input  busy, pe_sn, feed_cnt, a_lane_en, b_lane_en,
                           res_valid, res_row, done);
    modport slave  (input  start, res_ready,
                    output busy, pe_sn, feed_cnt, a_lane_en, b_lane_en,
                           res_valid, res_row, done);
`endif
endinterface

// File: rtl/systolic_seq_ctrl_skew_mask_gen.sv
// Skewed lane-enable mask: lane i is active while i <= t < i+K.
// Bounds are elaboration constants so no subtraction on t is needed.
module skew_mask_gen #(
    parameter int S  = 8,
    parameter int K  = 8,
    parameter int TW = 5
) (
    input  logic [TW-1:0] t_i,
    input  logic          en_i,
    output logic [S-1:0]  mask_o
);
    for (genvar i = 0; i < S; i++) begin : g_lane
        localparam logic [TW-1:0] LO = TW'(i);
        localparam logic [TW-1:0] HI = TW'(i + K);
        assign mask_o[i] = en_i && (t_i >= LO) && (t_i < HI);
    end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an S x S output-stationary systolic array:
// clear accumulators, feed skewed operands, drain result rows.
// Optional abort input enabled by SYSTOLIC_SEQ_CTRL_ABORT_EN.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N = 8,
    parameter int S = 8,
    parameter int K = 8
) (
    input  logic           clk,
    input  logic           rst,
    systolic_seq_ctrl_if.slave bus
);
    localparam int TW = cw(K + 2 * S - 1);
    localparam int RW = cw(S);
    localparam int T  = feed_len(K, S);

    // Operand width only travels with the array; reject nonsense configs.
    if (N < 1 || S < 1 || K < 1) begin : g_param_chk
        $error("systolic_seq_ctrl: N, S and K must all be >= 1");
    end

    seq_state_t    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [RW-1:0] row_q, row_d;
    logic          feeding;
    logic          draining;

    // State and counters; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            row_q   <= row_d;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
                row_d   = '0;
            end
            S_FEED: begin
                if (t_q == TW'(T - 1)) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.res_ready) begin
                    if (row_q == RW'(S - 1)) state_d = S_DONE;
                    else                     row_d   = row_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef SYSTOLIC_SEQ_CTRL_ABORT_EN
        if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
`endif
    end

    assign feeding  = (state_q == S_FEED);
    assign draining = (state_q == S_DRAIN);

    // Accumulators hold from the first feed until the job is closed out.
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.pe_sn     = feeding || draining || (state_q == S_DONE);
    assign bus.feed_cnt  = feeding ? t_q : '0;
    assign bus.res_valid = draining;
    assign bus.res_row   = draining ? row_q : '0;
    assign bus.done      = (state_q == S_DONE);

    skew_mask_gen #(.S(S), .K(K), .TW(TW)) u_a_mask (
        .t_i    (t_q),
        .en_i   (feeding),
        .mask_o (bus.a_lane_en)
    );

    skew_mask_gen #(.S(S), .K(K), .TW(TW)) u_b_mask (
        .t_i    (t_q),
        .en_i   (feeding),
        .mask_o (bus.b_lane_en)
    );

endmodule
